riscv_fetch_pc: RTL and testbench

Parametrised fetch-stage program-counter unit for the RV32I core. Holds the architectural PC and issues one-outstanding instruction-fetch requests to instruction memory over a req/ack handshake. Hands fetched PCs downstream over valid/ready and applies branch, jump, trap and trap-return redirects with correct squashing of in-flight fetches. Adds an exception PC register and misaligned-target detection.

---
 rtl/riscv_pc_pkg.sv | 18 +
 rtl/riscv_pc_target.sv | 46 ++++
 rtl/riscv_fetch_pc.sv | 128 ++++++++++++
 tb/tb_riscv_fetch_pc.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pc_pkg.sv
// Shared encodings for the RV32I fetch program-counter unit.
// Redirect modes, fetch FSM states and the sequential PC step.
`timescale 1ns/1ps
package riscv_pc_pkg;

    localparam logic [1:0] REDIR_REL  = 2'b00;
    localparam logic [1:0] REDIR_ABS  = 2'b01;
    localparam logic [1:0] REDIR_TRAP = 2'b10;
    localparam logic [1:0] REDIR_RET  = 2'b11;

    typedef enum logic {
        RUN     = 1'b0,
        DISCARD = 1'b1
    } pc_state_e;

    localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/riscv_pc_target.sv
// Redirect target resolution: picks the new PC per mode and
// diverts misaligned relative/absolute targets to the trap vector.
`timescale 1ns/1ps
module riscv_pc_target
    import riscv_pc_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [1:0]      i_mode,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_base,
    input  logic [XLEN-1:0] i_offset,
    input  logic [XLEN-1:0] i_epc,
    input  logic [XLEN-1:0] i_trap_vec,
    output logic [XLEN-1:0] o_target,
    output logic            o_misalign,
    output logic            o_epc_wr
);

    logic [XLEN-1:0] w_raw;
    logic [XLEN-1:0] w_abs;
    logic            w_bad;

    assign w_abs = i_base + i_offset;

    // Raw target per redirect mode; jalr drops bit 0.
    always_comb begin
        w_raw = i_epc;
        unique case (i_mode)
            REDIR_REL:  w_raw = i_pc + i_offset;
            REDIR_ABS:  w_raw = {w_abs[XLEN-1:1], 1'b0};
            REDIR_TRAP: w_raw = i_trap_vec;
            REDIR_RET:  w_raw = i_epc;
        endcase
    end

    // Only computed targets can be misaligned; those become traps.
    always_comb begin
        w_bad      = ((i_mode == REDIR_REL) || (i_mode == REDIR_ABS))
                     && (w_raw[1:0] != 2'b00);
        o_target   = w_bad ? i_trap_vec : w_raw;
        o_misalign = w_bad;
        o_epc_wr   = w_bad || (i_mode == REDIR_TRAP);
    end

endmodule

// File: rtl/riscv_fetch_pc.sv
// Fetch-stage PC unit: one-outstanding imem requests, one-entry
// output slot, redirects with squashing of in-flight fetches.
`timescale 1ns/1ps
module riscv_fetch_pc
    import riscv_pc_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0010
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redir_valid,
    input  logic [1:0]      redir_mode,
    input  logic [XLEN-1:0] redir_pc,
    input  logic [XLEN-1:0] redir_base,
    input  logic [XLEN-1:0] redir_offset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] epc,
    output logic            misalign
);

    pc_state_e       r_state;
    pc_state_e       w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_disc_addr;
    logic            r_hold;
    logic            r_if_valid;
    logic [XLEN-1:0] r_if_pc;
    logic [XLEN-1:0] r_epc;
    logic            r_misalign;

    logic            w_req;
    logic            w_acc;
    logic            w_slot_free;
    logic [XLEN-1:0] w_tgt;
    logic            w_tgt_mis;
    logic            w_epc_wr;

    riscv_pc_target #(
        .XLEN (XLEN)
    ) u_target (
        .i_mode     (redir_mode),
        .i_pc       (redir_pc),
        .i_base     (redir_base),
        .i_offset   (redir_offset),
        .i_epc      (r_epc),
        .i_trap_vec (TRAP_VECTOR),
        .o_target   (w_tgt),
        .o_misalign (w_tgt_mis),
        .o_epc_wr   (w_epc_wr)
    );

    assign w_slot_free = !r_if_valid || if_ready;
    assign w_acc       = imem_ack && w_req;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= RUN;
        else        r_state <= w_state_nxt;
    end

    // Next state: an unacked request caught by a redirect is discarded.
    always_comb begin
        w_state_nxt = r_state;
        if (redir_valid)
            w_state_nxt = (w_req && !imem_ack) ? DISCARD : RUN;
        else if ((r_state == DISCARD) && imem_ack)
            w_state_nxt = RUN;
    end

    // Request/address outputs; DISCARD keeps the squashed address up.
    always_comb begin
        w_req     = 1'b0;
        imem_addr = r_pc;
        unique case (r_state)
            RUN:     w_req = r_hold || w_slot_free;
            DISCARD: begin
                w_req     = 1'b1;
                imem_addr = r_disc_addr;
            end
        endcase
    end

    assign imem_req = w_req;

    // PC, output slot, exception PC and squash bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_VECTOR;
            r_disc_addr <= RESET_VECTOR;
            r_hold      <= 1'b0;
            r_if_valid  <= 1'b0;
            r_if_pc     <= '0;
            r_epc       <= '0;
            r_misalign  <= 1'b0;
        end else begin
            r_misalign <= redir_valid && w_tgt_mis;
            r_hold     <= (r_state == RUN) && w_req
                          && !imem_ack && !redir_valid;
            if (redir_valid) begin
                r_pc       <= w_tgt;
                r_if_valid <= 1'b0;
                if (w_epc_wr)
                    r_epc <= redir_pc;
                if ((r_state == RUN) && w_req && !imem_ack)
                    r_disc_addr <= r_pc;
            end else if ((r_state == RUN) && w_acc) begin
                r_if_pc    <= r_pc;
                r_if_valid <= 1'b1;
                r_pc       <= r_pc + XLEN'(PC_INC);
            end else if (if_ready) begin
                r_if_valid <= 1'b0;
            end
        end
    end

    assign if_valid = r_if_valid;
    assign if_pc    = r_if_pc;
    assign epc      = r_epc;
    assign misalign = r_misalign;

endmodule

// File: tb/tb_riscv_fetch_pc.sv
// Bench for riscv_fetch_pc: directed scenarios then random traffic,
// compared against a transaction-level fetch model.
`timescale 1ns/1ps
module tb_riscv_fetch_pc;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0010;

    logic        clk;
    logic        rst_n;
    logic        redir_valid;
    logic [1:0]  redir_mode;
    logic [31:0] redir_pc;
    logic [31:0] redir_base;
    logic [31:0] redir_offset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] epc;
    logic        misalign;

    riscv_fetch_pc #(
        .XLEN         (32),
        .RESET_VECTOR (RV),
        .TRAP_VECTOR  (TV)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .redir_valid  (redir_valid),
        .redir_mode   (redir_mode),
        .redir_pc     (redir_pc),
        .redir_base   (redir_base),
        .redir_offset (redir_offset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .if_valid     (if_valid),
        .if_ready     (if_ready),
        .if_pc        (if_pc),
        .epc          (epc),
        .misalign     (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Model: architectural PC, output slot, and the one request
    // currently on the bus (with a flag once it has been squashed).
    logic [31:0] m_pc, m_ifpc, m_epc, m_out_addr;
    logic        m_ifv, m_mis, m_out, m_out_dead;

    logic        o_req, o_ifv, o_mis;
    logic [31:0] o_addr, o_ifpc, o_epc;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc       = RV;
        m_ifpc     = '0;
        m_epc      = '0;
        m_ifv      = 1'b0;
        m_mis      = 1'b0;
        m_out      = 1'b0;
        m_out_dead = 1'b0;
        m_out_addr = '0;
    endtask

    task automatic step(input logic rdy, input logic ack_en,
                        input logic rv, input logic [1:0] md,
                        input logic [31:0] rp, input logic [31:0] rb,
                        input logic [31:0] ro);
        logic        a_req, ack, bad, dlv;
        logic [31:0] a_addr, t;
        @(negedge clk);
        if_ready     = rdy;
        redir_valid  = rv;
        redir_mode   = md;
        redir_pc     = rp;
        redir_base   = rb;
        redir_offset = ro;
        a_req  = m_out || !m_ifv || rdy;
        a_addr = m_out ? m_out_addr : m_pc;
        ack    = ack_en && a_req;
        imem_ack = ack;
        #1;
        o_req  = imem_req;
        o_addr = imem_addr;
        o_ifv  = if_valid;
        o_ifpc = if_pc;
        o_epc  = epc;
        o_mis  = misalign;
        chk("imem_req", {31'd0, imem_req}, {31'd0, a_req});
        if (a_req) chk("imem_addr", imem_addr, a_addr);
        chk("if_valid", {31'd0, if_valid}, {31'd0, m_ifv});
        chk("if_pc", if_pc, m_ifpc);
        chk("epc", epc, m_epc);
        chk("misalign", {31'd0, misalign}, {31'd0, m_mis});
        @(posedge clk);
        dlv = 1'b0;
        if (a_req && ack) begin
            if (!(m_out && m_out_dead) && !rv) begin
                m_ifpc = a_addr;
                m_ifv  = 1'b1;
                m_pc   = a_addr + 32'd4;
                dlv    = 1'b1;
            end
            m_out      = 1'b0;
            m_out_dead = 1'b0;
        end else if (a_req) begin
            m_out_dead = (m_out && m_out_dead) || rv;
            m_out      = 1'b1;
            m_out_addr = a_addr;
        end
        if (rv) begin
            case (md)
                2'd0:    t = rp + ro;
                2'd1:    t = (rb + ro) & 32'hFFFF_FFFE;
                2'd2:    t = TV;
                default: t = m_epc;
            endcase
            bad = (md < 2'd2) && ((t % 4) != 0);
            if (bad || md == 2'd2) m_epc = rp;
            m_pc  = bad ? TV : t;
            m_ifv = 1'b0;
            m_mis = bad;
        end else begin
            m_mis = 1'b0;
            if (!dlv && rdy) m_ifv = 1'b0;
        end
    endtask

    task automatic run(input logic rdy, input logic ack_en);
        step(rdy, ack_en, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0);
    endtask

    initial begin
        logic        r_rdy, r_ack, r_rv;
        logic [1:0]  r_md;
        logic [31:0] r_rp, r_rb, r_ro;
        rst_n        = 1'b0;
        redir_valid  = 1'b0;
        redir_mode   = 2'd0;
        redir_pc     = '0;
        redir_base   = '0;
        redir_offset = '0;
        imem_ack     = 1'b0;
        if_ready     = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_epc", epc, 32'd0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);
        chk("rst_addr", imem_addr, RV);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run(1'b1, 1'b1);
            chk("seq_addr", o_addr, 32'(i * 4));
            if (i > 0) chk("seq_ifpc", o_ifpc, 32'((i - 1) * 4));
        end

        for (int i = 0; i < 3; i++) begin
            run(1'b0, 1'b1);
            chk("stall_req", {31'd0, o_req}, 32'd0);
            chk("stall_ifpc", o_ifpc, 32'd20);
        end
        run(1'b1, 1'b1);
        chk("resume_addr", o_addr, 32'd24);

        step(1'b1, 1'b1, 1'b1, 2'd0, 32'h100, 32'd0, 32'hC);
        run(1'b1, 1'b0);
        chk("redir_ack_ifv", {31'd0, o_ifv}, 32'd0);
        chk("redir_ack_addr", o_addr, 32'h10C);
        step(1'b1, 1'b0, 1'b1, 2'd0, 32'h100, 32'd0, 32'hFFFF_FFF8);
        run(1'b1, 1'b1);
        chk("discard_addr", o_addr, 32'h10C);
        run(1'b1, 1'b1);
        chk("after_discard_addr", o_addr, 32'hF8);
        chk("discard_dropped", {31'd0, o_ifv}, 32'd0);
        run(1'b1, 1'b0);
        chk("target_ifpc", o_ifpc, 32'hF8);

        step(1'b1, 1'b0, 1'b1, 2'd1, 32'h40, 32'h203, 32'd0);
        run(1'b1, 1'b1);
        chk("mis_pulse", {31'd0, o_mis}, 32'd1);
        chk("mis_epc", o_epc, 32'h40);
        run(1'b1, 1'b0);
        chk("mis_pulse_end", {31'd0, o_mis}, 32'd0);
        chk("trap_addr", o_addr, TV);
        step(1'b1, 1'b1, 1'b1, 2'd3, 32'd0, 32'd0, 32'd0);
        run(1'b1, 1'b1);
        chk("ret_addr", o_addr, 32'h40);
        chk("ret_ifv", {31'd0, o_ifv}, 32'd0);

        step(1'b1, 1'b0, 1'b1, 2'd0, 32'd0, 32'd0, 32'hFFFF_FFFC);
        run(1'b1, 1'b1);
        run(1'b1, 1'b1);
        chk("top_addr", o_addr, 32'hFFFF_FFFC);
        run(1'b1, 1'b1);
        chk("wrap_addr", o_addr, 32'h0);
        chk("wrap_ifpc", o_ifpc, 32'hFFFF_FFFC);

        for (int i = 0; i < 400; i++) begin
            r_rdy = ($urandom_range(0, 3) != 0);
            r_ack = ($urandom_range(0, 2) != 0);
            r_rv  = ($urandom_range(0, 5) == 0);
            r_md  = 2'($urandom_range(0, 3));
            r_rp  = $urandom & 32'hFFFF_FFFC;
            r_rb  = ($urandom & 32'hFFFF_FFFC)
                    | (($urandom_range(0, 3) == 0) ?
                       32'($urandom_range(1, 3)) : 32'd0);
            if ($urandom_range(0, 7) == 0)
                r_ro = $urandom;
            else
                r_ro = 32'($urandom_range(0, 63)) * 32'd4 - 32'd128;
            step(r_rdy, r_ack, r_rv, r_md, r_rp, r_rb, r_ro);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
